// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an 8:1 mux. It steps sel through channels 0..7, samples mux_y at the end of
// each dwell, and publishes an 8-bit frame. MUX_SCAN_PARITY_EN adds an even-parity bit on frame.
module mux_scan_ctrl #(
   parameter int DWELL_CYCLES = 4,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       continuous,
   input  logic       mux_y,
   output logic [2:0] sel,
   output logic       busy,
   output logic       sample_valid,
   output logic [2:0] sample_ch,
   output logic       sample_bit,
   output logic [7:0] frame,
`ifdef MUX_SCAN_PARITY_EN
   output logic       frame_parity,
`endif
   output logic       frame_valid
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYCLES - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [7:0]       shadow_reg;
   logic [7:0]       shadow_next;
   logic [7:0]       frame_next;
   logic             capture;

   assign capture = (state_reg == SCAN) && (cnt_reg == '0);

   // Only the channel currently on sel is overwritten at a capture.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_shadow
         assign shadow_next[gi] = (capture && (sel == 3'(gi))) ? mux_y : shadow_reg[gi];
      end
   endgenerate

   // Channel 7 comes straight from mux_y so the frame is complete on the capture edge.
   assign frame_next = {mux_y, shadow_reg[6:0]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         shadow_reg   <= '0;
         sel          <= '0;
         busy         <= 1'b0;
         sample_valid <= 1'b0;
         sample_ch    <= '0;
         sample_bit   <= 1'b0;
         frame        <= '0;
         frame_valid  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
         frame_parity <= 1'b0;
`endif
      end else begin
         sample_valid <= 1'b0;
         frame_valid  <= 1'b0;
         case (state_reg)
            IDLE: begin
               sel <= '0;
               if (start) begin
                  state_reg <= SCAN;
                  cnt_reg   <= RELOAD;
                  busy      <= 1'b1;
               end
            end
            SCAN: begin
               if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - 1'b1;
               end else begin
                  shadow_reg   <= shadow_next;
                  sample_valid <= 1'b1;
                  sample_ch    <= sel;
                  sample_bit   <= mux_y;
                  cnt_reg      <= RELOAD;
                  if (sel != 3'd7) begin
                     sel <= sel + 3'd1;
                  end else begin
                     frame       <= frame_next;
                     frame_valid <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                     frame_parity <= ^frame_next;
`endif
                     sel <= '0;
                     // continuous is only looked at here, so a frame in flight always completes.
                     if (!continuous) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                     end
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (dwell 4 and dwell 1) checked every cycle against a
// timeline model, plus a vector table and directed multi-cycle sequences.
module tb_mux_scan_ctrl;

   localparam int D0 = 4;
   localparam int D1 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n [2];
   logic       start [2];
   logic       cont  [2];
   logic       mux_y [2];
   logic [7:0] pat   [2];
   logic [2:0] sel   [2];
   logic       busy  [2];
   logic       sv    [2];
   logic [2:0] sch   [2];
   logic       sbit  [2];
   logic [7:0] frame [2];
   logic       fv    [2];
`ifdef MUX_SCAN_PARITY_EN
   logic       par   [2];
`endif

   int n_checks = 0;
   int n_fail   = 0;

   assign mux_y[0] = pat[0][sel[0]];
   assign mux_y[1] = pat[1][sel[1]];

   mux_scan_ctrl #(.DWELL_CYCLES(D0), .CNT_W(8)) u_d4 (
      .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .continuous(cont[0]), .mux_y(mux_y[0]),
      .sel(sel[0]), .busy(busy[0]), .sample_valid(sv[0]), .sample_ch(sch[0]),
      .sample_bit(sbit[0]), .frame(frame[0]),
`ifdef MUX_SCAN_PARITY_EN
      .frame_parity(par[0]),
`endif
      .frame_valid(fv[0])
   );

   mux_scan_ctrl #(.DWELL_CYCLES(D1), .CNT_W(8)) u_d1 (
      .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .continuous(cont[1]), .mux_y(mux_y[1]),
      .sel(sel[1]), .busy(busy[1]), .sample_valid(sv[1]), .sample_ch(sch[1]),
      .sample_bit(sbit[1]), .frame(frame[1]),
`ifdef MUX_SCAN_PARITY_EN
      .frame_parity(par[1]),
`endif
      .frame_valid(fv[1])
   );

   function automatic int dwell(input int i);
      return (i == 0) ? D0 : D1;
   endfunction

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s u%0d t=%0t got=%0h expected=%0h", nm, i, $time, act, exp);
      end
   endtask

   // Reference model: a scan is a timeline of 8*dwell cycles; the channel is elapsed/dwell and a
   // capture happens whenever a dwell period completes.
   bit         m_act    [2] = '{0, 0};
   int         m_el     [2] = '{0, 0};
   logic [7:0] m_shadow [2] = '{8'h00, 8'h00};
   logic [7:0] m_frame  [2] = '{8'h00, 8'h00};
   logic       m_sv     [2] = '{1'b0, 1'b0};
   logic       m_fv     [2] = '{1'b0, 1'b0};
   logic       m_bit    [2] = '{1'b0, 1'b0};
   logic       m_par    [2] = '{1'b0, 1'b0};
   logic [2:0] m_ch     [2] = '{3'd0, 3'd0};

   task automatic model_step(input int i);
      int d;
      int k;
      d = dwell(i);
      m_sv[i] = 1'b0;
      m_fv[i] = 1'b0;
      if (!rst_n[i]) begin
         m_act[i] = 0; m_el[i] = 0; m_shadow[i] = '0; m_frame[i] = '0;
         m_ch[i] = '0; m_bit[i] = 1'b0; m_par[i] = 1'b0;
      end else if (!m_act[i]) begin
         if (start[i]) begin
            m_act[i] = 1;
            m_el[i]  = 0;
         end
      end else begin
         if ((m_el[i] + 1) % d == 0) begin
            k = m_el[i] / d;
            m_shadow[i][k] = pat[i][k];
            m_sv[i]  = 1'b1;
            m_ch[i]  = 3'(k);
            m_bit[i] = pat[i][k];
            if (k == 7) begin
               m_frame[i] = m_shadow[i];
               m_fv[i]    = 1'b1;
               m_par[i]   = ^m_shadow[i];
            end
         end
         m_el[i]++;
         if (m_el[i] == 8 * d) begin
            m_el[i] = 0;
            if (!cont[i]) m_act[i] = 0;
         end
      end
   endtask

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) model_step(i);
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk("m_sel", i, 32'(sel[i]), m_act[i] ? 32'(m_el[i] / dwell(i)) : 32'd0);
         chk("m_busy", i, 32'(busy[i]), 32'(m_act[i]));
         chk("m_sample_valid", i, 32'(sv[i]), 32'(m_sv[i]));
         chk("m_sample_ch", i, 32'(sch[i]), 32'(m_ch[i]));
         chk("m_sample_bit", i, 32'(sbit[i]), 32'(m_bit[i]));
         chk("m_frame", i, 32'(frame[i]), 32'(m_frame[i]));
         chk("m_frame_valid", i, 32'(fv[i]), 32'(m_fv[i]));
`ifdef MUX_SCAN_PARITY_EN
         chk("m_parity", i, 32'(par[i]), 32'(m_par[i]));
`endif
      end
   end

   // One start pulse, then follow the scan until frame_valid (bounded).
   task automatic run_scan(input int i, input logic c, output logic [7:0] fr, output logic p,
                           output int lat, output int nsv, output bit ok);
      fr = '0; p = 1'b0; nsv = 0; ok = 0; lat = 0;
      cont[i]  = c;
      start[i] = 1'b1;
      @(negedge clk);
      start[i] = 1'b0;
      for (int n = 1; n <= 300; n++) begin
         lat = n;
         if (sv[i]) begin
            chk("scan_sample_ch", i, 32'(sch[i]), 32'(nsv));
            nsv++;
         end
         if (fv[i]) begin
            ok = 1;
            fr = frame[i];
`ifdef MUX_SCAN_PARITY_EN
            p = par[i];
`endif
            break;
         end
         @(negedge clk);
      end
   endtask

   typedef struct {
      int         inst;
      logic [7:0] pattern;
      logic [7:0] exp_frame;
      logic       exp_par;
   } vec_t;

   vec_t       tbl [6];
   logic [7:0] fr;
   logic       p;
   int         lat, nsv, cnt_fv, cnt_sv, cyc;
   bit         ok;

   initial begin
      tbl[0] = '{0, 8'hA5, 8'hA5, 1'b0};
      tbl[1] = '{1, 8'h3C, 8'h3C, 1'b0};
      tbl[2] = '{0, 8'h07, 8'h07, 1'b1};
      tbl[3] = '{0, 8'h0F, 8'h0F, 1'b0};
      tbl[4] = '{1, 8'hFF, 8'hFF, 1'b0};
      tbl[5] = '{1, 8'h80, 8'h80, 1'b1};

      for (int i = 0; i < 2; i++) begin
         rst_n[i] = 1'b0; start[i] = 1'b0; cont[i] = 1'b0; pat[i] = 8'h00;
      end

      // Reset then idle
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_sel", i, 32'(sel[i]), 32'd0);
         chk("rst_busy", i, 32'(busy[i]), 32'd0);
         chk("rst_frame", i, 32'(frame[i]), 32'h00);
         rst_n[i] = 1'b1;
      end
      cnt_sv = 0; cnt_fv = 0;
      repeat (20) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (sv[i]) cnt_sv++;
            if (fv[i]) cnt_fv++;
         end
      end
      chk("idle_pulses", 0, 32'(cnt_sv + cnt_fv), 32'd0);

      // Vector table: single scans
      for (int t = 0; t < 6; t++) begin
         pat[tbl[t].inst] = tbl[t].pattern;
         run_scan(tbl[t].inst, 1'b0, fr, p, lat, nsv, ok);
         chk("tbl_timeout", tbl[t].inst, 32'(ok), 32'd1);
         chk("tbl_frame", tbl[t].inst, 32'(fr), 32'(tbl[t].exp_frame));
         chk("tbl_latency", tbl[t].inst, 32'(lat), 32'(8 * dwell(tbl[t].inst) + 1));
         chk("tbl_nsamples", tbl[t].inst, 32'(nsv), 32'd8);
         chk("tbl_busy_end", tbl[t].inst, 32'(busy[tbl[t].inst]), 32'd0);
`ifdef MUX_SCAN_PARITY_EN
         chk("tbl_parity", tbl[t].inst, 32'(p), 32'(tbl[t].exp_par));
`endif
         @(negedge clk);
         chk("tbl_fv_single", tbl[t].inst, 32'(fv[tbl[t].inst]), 32'd0);
         repeat (2) @(negedge clk);
      end

      // Continuous, dwell 1: 3C then C3, then drop continuous mid-frame
      pat[1] = 8'h3C;
      run_scan(1, 1'b1, fr, p, lat, nsv, ok);
      chk("cont_frame0", 1, 32'(fr), 32'h3C);
      pat[1] = 8'hC3;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!fv[1] && cyc < 50);
      chk("cont_period", 1, 32'(cyc), 32'd8);
      chk("cont_frame1", 1, 32'(frame[1]), 32'hC3);
      repeat (3) @(negedge clk);
      cont[1] = 1'b0;
      cnt_fv = 0;
      repeat (30) begin
         @(negedge clk);
         if (fv[1]) cnt_fv++;
      end
      chk("cont_drop_frames", 1, 32'(cnt_fv), 32'd1);
      chk("cont_drop_busy", 1, 32'(busy[1]), 32'd0);

      // start while busy is ignored
      pat[0] = 8'h5A;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      cyc = 0;
      while (sel[0] != 3'd3 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("busy_reach_ch3", 0, 32'(sel[0]), 32'd3);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      cnt_fv = 0;
      repeat (60) begin
         @(negedge clk);
         if (fv[0]) begin
            cnt_fv++;
            chk("busy_frame", 0, 32'(frame[0]), 32'h5A);
         end
      end
      chk("busy_single_frame", 0, 32'(cnt_fv), 32'd1);
      chk("busy_idle_after", 0, 32'(busy[0]), 32'd0);

      // Reset mid-scan after a FF frame
      pat[0] = 8'hFF;
      run_scan(0, 1'b0, fr, p, lat, nsv, ok);
      chk("rstmid_prior", 0, 32'(fr), 32'hFF);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      cyc = 0;
      while (sel[0] != 3'd5 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("rstmid_reach_ch5", 0, 32'(sel[0]), 32'd5);
      rst_n[0] = 1'b0;
      @(negedge clk);
      rst_n[0] = 1'b1;
      chk("rstmid_frame", 0, 32'(frame[0]), 32'h00);
      chk("rstmid_sel", 0, 32'(sel[0]), 32'd0);
      chk("rstmid_busy", 0, 32'(busy[0]), 32'd0);
      pat[0] = 8'hA5;
      run_scan(0, 1'b0, fr, p, lat, nsv, ok);
      chk("rstmid_rescan", 0, 32'(fr), 32'hA5);
      chk("rstmid_rescan_lat", 0, 32'(lat), 32'(8 * D0 + 1));

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 2; i++) begin
            start[i] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) cont[i] = ~cont[i];
            pat[i]   = 8'($urandom);
            rst_n[i] = ($urandom_range(0, 199) != 0);
         end
         @(negedge clk);
      end
      for (int i = 0; i < 2; i++) begin
         start[i] = 1'b0; cont[i] = 1'b0; rst_n[i] = 1'b1;
      end
      repeat (80) @(negedge clk);
      chk("end_idle0", 0, 32'(busy[0]), 32'd0);
      chk("end_idle1", 1, 32'(busy[1]), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
